// File: rtl/queue_dispatcher_pkg.sv
// +----------------------------------------------------------------------+
// | queue_dispatcher_pkg : shared constants for the queue dispatcher      |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

`ifndef QD_SEL_BITS
`define QD_SEL_BITS(n) (((n) > 1) ? $clog2(n) : 1)
`endif

package queue_dispatcher_pkg;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_hold  = 2'd1;
  localparam logic [1:0] c_st_stall = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = c_st_idle,
    HOLD  = c_st_hold,
    STALL = c_st_stall
  } qd_state_e;

  localparam int c_cnt_bits = 8;
  localparam logic [c_cnt_bits-1:0] c_cnt_max = {c_cnt_bits{1'b1}};

endpackage

`default_nettype wire

// File: rtl/queue_dispatcher_decoder.sv
// +----------------------------------------------------------------------+
// | dispatch_decoder : destination index to one-hot push strobe           |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module dispatch_decoder #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int SEL_BITS       = 2
) (
  input  logic [SEL_BITS-1:0]       i_dest,
  input  logic                      i_valid,
  output logic [QUEUE_QUANTITY-1:0] o_onehot
);

  generate
    for (genvar i = 0; i < QUEUE_QUANTITY; i++) begin : g_onehot
      assign o_onehot[i] = i_valid && (i_dest == SEL_BITS'(i));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/queue_dispatcher.sv
// +----------------------------------------------------------------------+
// | queue_dispatcher : one-word holding stage that routes words into      |
// | per-destination FIFOs. Optional push counters: DISPATCH_COUNT_EN.     |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module queue_dispatcher
  import queue_dispatcher_pkg::*;
#(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enb,
  input  logic [DATA_BITS-1:0]      data_in,
  input  logic                      data_in_valid,
  output logic                      data_in_ready,
  input  logic [QUEUE_QUANTITY-1:0] buf_full,
  input  logic [QUEUE_QUANTITY-1:0] almost_full,
  output logic [QUEUE_QUANTITY-1:0] push,
  output logic [DATA_BITS-1:0]      data_out,
  output logic                      pause
`ifdef DISPATCH_COUNT_EN
  ,
  output logic [QUEUE_QUANTITY*c_cnt_bits-1:0] push_count
`endif
);

  localparam int SEL_BITS = `QD_SEL_BITS(QUEUE_QUANTITY);

  qd_state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]      hold_q, hold_d;
  logic [SEL_BITS-1:0]       dest_q, dest_d;
  logic [DATA_BITS-1:0]      data_out_q, data_out_d;
  logic [QUEUE_QUANTITY-1:0] push_q, push_d;
  logic                      pause_q, pause_d;

  logic                      w_target_full;
  logic                      w_ready;
  logic                      w_accept;
  logic                      w_do_push;
  logic [QUEUE_QUANTITY-1:0] w_push_onehot;

  // Only the held word's own queue can stall the stage.
  assign w_target_full = buf_full[dest_q];

  assign w_ready   = enb && !rst &&
                     ((state_q == IDLE) || ((state_q == HOLD) && !w_target_full));
  assign w_accept  = data_in_valid && w_ready;
  assign w_do_push = enb && ((state_q == HOLD) || (state_q == STALL)) && !w_target_full;

  dispatch_decoder #(
    .QUEUE_QUANTITY (QUEUE_QUANTITY),
    .SEL_BITS       (SEL_BITS)
  ) u_decoder (
    .i_dest   (dest_q),
    .i_valid  (w_do_push),
    .o_onehot (w_push_onehot)
  );

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    dest_d     = dest_q;
    data_out_d = data_out_q;
    pause_d    = pause_q;
    push_d     = w_push_onehot;

    if (enb) begin
      pause_d = |almost_full;
      if (w_do_push) begin
        data_out_d = hold_q;
      end

      case (state_q)
        IDLE: begin
          if (w_accept) begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (w_target_full) begin
            state_d = STALL;
          end else if (w_accept) begin
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end
        // Input stays closed here; the drain edge leaves the stage empty.
        STALL: begin
          if (!w_target_full) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (w_accept) begin
        hold_d = data_in;
        dest_d = data_in[DATA_BITS-1 -: SEL_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      dest_q     <= '0;
      data_out_q <= '0;
      push_q     <= '0;
      pause_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      dest_q     <= dest_d;
      data_out_q <= data_out_d;
      push_q     <= push_d;
      pause_q    <= pause_d;
    end
  end

  assign data_in_ready = w_ready;
  assign push          = push_q;
  assign data_out      = data_out_q;
  assign pause         = pause_q;

`ifdef DISPATCH_COUNT_EN
  logic [QUEUE_QUANTITY*c_cnt_bits-1:0] count_q, count_d;

  // Counted on the deciding edge so each slot moves together with its strobe.
  always_comb begin
    count_d = count_q;
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      if (push_d[i] && (count_q[i*c_cnt_bits +: c_cnt_bits] != c_cnt_max)) begin
        count_d[i*c_cnt_bits +: c_cnt_bits] = count_q[i*c_cnt_bits +: c_cnt_bits] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign push_count = count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_queue_dispatcher.sv
// +----------------------------------------------------------------------+
// | tb_queue_dispatcher : directed table plus randomized model check      |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_queue_dispatcher;

  typedef struct {
    logic       rst;
    logic       enb;
    logic       valid;
    logic [7:0] data;
    logic [3:0] full;
    logic [3:0] af;
    logic       ready;
    logic [3:0] push;
    logic [7:0] dout;
    logic       pause;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic [3:0] buf_full;
  logic [3:0] almost_full;
  logic [3:0] push;
  logic [7:0] data_out;
  logic       pause;
`ifdef DISPATCH_COUNT_EN
  logic [31:0] push_count;
`endif

  always #5 clk = ~clk;

  queue_dispatcher #(
    .QUEUE_QUANTITY (4),
    .DATA_BITS      (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enb           (enb),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .buf_full      (buf_full),
    .almost_full   (almost_full),
    .push          (push),
    .data_out      (data_out),
    .pause         (pause)
`ifdef DISPATCH_COUNT_EN
    ,
    .push_count    (push_count)
`endif
  );

  // Reference: a single slot holding at most one word, plus a flag that the
  // word has already been refused once (which keeps the input closed).
  bit         m_held;
  bit         m_refused;
  logic [7:0] m_word;
  logic [3:0] m_push;
  logic [7:0] m_dout;
  bit         m_pause;
  int         m_cnt[4];

  int n_vec = 0;
  int n_bad = 0;

  vec_t tab[27];

  function automatic vec_t mk(input logic r, input logic e, input logic v,
                              input logic [7:0] d, input logic [3:0] f, input logic [3:0] a,
                              input logic xr, input logic [3:0] xp, input logic [7:0] xd,
                              input logic xpa);
    vec_t t;
    t.rst = r; t.enb = e; t.valid = v; t.data = d; t.full = f; t.af = a;
    t.ready = xr; t.push = xp; t.dout = xd; t.pause = xpa;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered 1 time unit after a posedge; checks at the negedge, then clocks.
  task automatic step(input vec_t v, input bit use_tab);
    bit       exp_ready;
    bit       push_now;
    bit       acc;
    int       d;
    rst           = v.rst;
    enb           = v.enb;
    data_in_valid = v.valid;
    data_in       = v.data;
    buf_full      = v.full;
    almost_full   = v.af;
    d = int'(m_word[7:6]);
    exp_ready = v.enb && !v.rst && (!m_held || (!m_refused && !v.full[d]));
    #4;
    check("ready", {31'd0, data_in_ready}, {31'd0, exp_ready});
    check("push", {28'd0, push}, {28'd0, m_push});
    check("data_out", {24'd0, data_out}, {24'd0, m_dout});
    check("pause", {31'd0, pause}, {31'd0, m_pause});
    if (use_tab) begin
      check("tab_ready", {31'd0, data_in_ready}, {31'd0, v.ready});
      check("tab_push", {28'd0, push}, {28'd0, v.push});
      check("tab_data_out", {24'd0, data_out}, {24'd0, v.dout});
      check("tab_pause", {31'd0, pause}, {31'd0, v.pause});
    end
`ifdef DISPATCH_COUNT_EN
    for (int q = 0; q < 4; q++) begin
      check("push_count", {24'd0, push_count[q*8 +: 8]}, 32'(m_cnt[q]));
    end
`endif
    @(posedge clk);
    if (v.rst) begin
      m_held = 0; m_refused = 0; m_push = '0; m_dout = '0; m_pause = 0;
      for (int q = 0; q < 4; q++) m_cnt[q] = 0;
    end else if (v.enb) begin
      push_now = m_held && !v.full[d];
      acc      = v.valid && exp_ready;
      m_pause  = |v.af;
      m_push   = push_now ? 4'(1 << d) : 4'd0;
      if (push_now) begin
        m_dout = m_word;
        if (m_cnt[d] < 255) m_cnt[d]++;
      end
      if (acc) begin
        m_held = 1; m_refused = 0; m_word = v.data;
      end else if (push_now) begin
        m_held = 0;
      end else if (m_held) begin
        m_refused = 1;
      end
    end else begin
      m_push = '0;
    end
    #1;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; enb = 1'b1; data_in_valid = 1'b0; data_in = '0;
    buf_full = '0; almost_full = '0;
    m_held = 0; m_refused = 0; m_word = '0; m_push = '0; m_dout = '0; m_pause = 0;
    for (int q = 0; q < 4; q++) m_cnt[q] = 0;
    @(posedge clk);
    #1;

    //           rst en vl data   full   af   | rdy push  dout  pause
    tab[0]  = mk(1, 1, 1, 8'h05, 4'h0, 4'h0,  0, 4'h0, 8'h00, 0);
    tab[1]  = mk(0, 1, 1, 8'h05, 4'h0, 4'h0,  1, 4'h0, 8'h00, 0);
    tab[2]  = mk(0, 1, 0, 8'h00, 4'h0, 4'h0,  1, 4'h0, 8'h00, 0);
    tab[3]  = mk(0, 1, 0, 8'h00, 4'h0, 4'h0,  1, 4'h1, 8'h05, 0);
    tab[4]  = mk(0, 1, 1, 8'h41, 4'h0, 4'h0,  1, 4'h0, 8'h05, 0);
    tab[5]  = mk(0, 1, 1, 8'h82, 4'h0, 4'h0,  1, 4'h0, 8'h05, 0);
    tab[6]  = mk(0, 1, 1, 8'hC3, 4'h0, 4'h0,  1, 4'h2, 8'h41, 0);
    tab[7]  = mk(0, 1, 0, 8'h00, 4'h0, 4'h0,  1, 4'h4, 8'h82, 0);
    tab[8]  = mk(0, 1, 0, 8'h00, 4'h0, 4'h0,  1, 4'h8, 8'hC3, 0);
    tab[9]  = mk(0, 1, 1, 8'hC7, 4'h8, 4'h0,  1, 4'h0, 8'hC3, 0);
    tab[10] = mk(0, 1, 0, 8'h00, 4'h8, 4'h0,  0, 4'h0, 8'hC3, 0);
    tab[11] = mk(0, 1, 1, 8'h11, 4'h8, 4'h0,  0, 4'h0, 8'hC3, 0);
    tab[12] = mk(0, 1, 1, 8'h11, 4'h0, 4'h0,  0, 4'h0, 8'hC3, 0);
    tab[13] = mk(0, 1, 1, 8'h11, 4'hE, 4'h0,  1, 4'h8, 8'hC7, 0);
    tab[14] = mk(0, 1, 0, 8'h00, 4'hE, 4'h0,  1, 4'h0, 8'hC7, 0);
    tab[15] = mk(0, 1, 0, 8'h00, 4'h0, 4'h4,  1, 4'h1, 8'h11, 0);
    tab[16] = mk(0, 1, 1, 8'h85, 4'h0, 4'h4,  1, 4'h0, 8'h11, 1);
    tab[17] = mk(0, 0, 1, 8'h99, 4'h0, 4'h0,  0, 4'h0, 8'h11, 1);
    tab[18] = mk(0, 0, 0, 8'h00, 4'h0, 4'h0,  0, 4'h0, 8'h11, 1);
    tab[19] = mk(0, 1, 0, 8'h00, 4'h0, 4'h0,  1, 4'h0, 8'h11, 1);
    tab[20] = mk(0, 1, 0, 8'h00, 4'h0, 4'h0,  1, 4'h4, 8'h85, 0);
    tab[21] = mk(0, 1, 0, 8'h00, 4'h0, 4'h0,  1, 4'h0, 8'h85, 0);
    tab[22] = mk(0, 1, 1, 8'hC0, 4'h8, 4'h0,  1, 4'h0, 8'h85, 0);
    tab[23] = mk(0, 1, 0, 8'h00, 4'h8, 4'h0,  0, 4'h0, 8'h85, 0);
    tab[24] = mk(1, 1, 0, 8'h00, 4'h0, 4'h0,  0, 4'h0, 8'h85, 0);
    tab[25] = mk(0, 1, 0, 8'h00, 4'h0, 4'h0,  1, 4'h0, 8'h00, 0);
    tab[26] = mk(0, 1, 0, 8'h00, 4'h0, 4'h0,  1, 4'h0, 8'h00, 0);

    for (int i = 0; i < 27; i++) step(tab[i], 1'b1);

    // Randomized traffic with occasional resets, enable drops and full flags.
    for (int i = 0; i < 3000; i++) begin
      v.rst   = ($urandom_range(0, 99) == 0);
      v.enb   = ($urandom_range(0, 9) != 0);
      v.valid = ($urandom_range(0, 9) < 7);
      v.data  = 8'($urandom);
      for (int b = 0; b < 4; b++) begin
        v.full[b] = ($urandom_range(0, 3) == 0);
        v.af[b]   = ($urandom_range(0, 5) == 0);
      end
      v.ready = 0; v.push = '0; v.dout = '0; v.pause = 0;
      step(v, 1'b0);
    end

`ifdef DISPATCH_COUNT_EN
    step(mk(1, 1, 0, 8'h00, 4'h0, 4'h0, 0, 4'h0, 8'h00, 0), 1'b0);
    for (int i = 0; i < 300; i++) begin
      step(mk(0, 1, 1, {2'b01, 6'(i)}, 4'h0, 4'h0, 0, 4'h0, 8'h00, 0), 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      step(mk(0, 1, 1, {2'b10, 6'(i)}, 4'h0, 4'h0, 0, 4'h0, 8'h00, 0), 1'b0);
    end
    step(mk(0, 1, 0, 8'h00, 4'h0, 4'h0, 0, 4'h0, 8'h00, 0), 1'b0);
    step(mk(0, 1, 0, 8'h00, 4'h0, 4'h0, 0, 4'h0, 8'h00, 0), 1'b0);
    check("cnt_q1_sat", {24'd0, push_count[15:8]}, 32'd255);
    check("cnt_q2", {24'd0, push_count[23:16]}, 32'd5);
    check("cnt_q0", {24'd0, push_count[7:0]}, 32'd0);
    check("cnt_q3", {24'd0, push_count[31:24]}, 32'd0);
    step(mk(1, 1, 0, 8'h00, 4'h0, 4'h0, 0, 4'h0, 8'h00, 0), 1'b0);
    check("cnt_rst", push_count, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
